// File: rtl/recver_pkg.sv
// Shared types and widths for the NAP stream LED receiver.
package recver_pkg;

    typedef enum logic {IDLE, HOLD} state_t;

    localparam int unsigned LED_W  = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/t_data_stream.sv
// NAP data-stream bundle: valid/ready handshake carrying an 8-bit word and 4-bit source address.
interface t_DATA_STREAM;
    import recver_pkg::*;

    logic              valid;
    logic              ready;
    logic [LED_W-1:0]  data;
    logic [ADDR_W-1:0] addr;

    modport rx (input valid, input data, input addr, output ready);
    modport tx (output valid, output data, output addr, input ready);
endinterface

// File: rtl/stream_fifo.sv
// Occupancy-counted FIFO with registered full/empty flags; DEPTH must be a power of two.
module stream_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic [OCC_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (do_pop && !do_push)
            count_next = count - 1'b1;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == OCC_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/stream_led_recver.sv
// Buffers NAP stream words and shows each on the LEDs for HOLD_CYCLES clocks.
// Optional source-address filter: define RECVER_SRC_FILTER_EN.
module stream_led_recver
    import recver_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned HOLD_CYCLES = 20000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] expected_src,
    t_DATA_STREAM.rx          nap,
    output logic [LED_W-1:0]  led,
    output logic [CNT_W-1:0]  rx_count,
    output logic [CNT_W-1:0]  drop_count
);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              run;
    logic              avail;
    logic              full;
    logic              empty;
    logic              xfer;
    logic              keep;
    logic              push;
    logic              drop;
    logic              pop;
    logic [LED_W-1:0]  head;

`ifdef RECVER_SRC_FILTER_EN
    assign keep = (nap.addr == expected_src);
`else
    logic unused_src;
    assign keep       = 1'b1;
    assign unused_src = ^{expected_src, nap.addr};
`endif

    assign nap.ready = run & ~full;
    assign xfer      = nap.valid & nap.ready;
    assign push      = xfer & keep;
    assign drop      = xfer & ~keep;
    assign pop       = (state == IDLE) & avail;

    stream_fifo #(
        .WIDTH (LED_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .push  (push),
        .pop   (pop),
        .din   (nap.data),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // avail lags the FIFO empty flag by a cycle (giving the two-cycle display
    // latency) and is cleared on a pop so the same entry is never taken twice.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run        <= 1'b0;
            avail      <= 1'b0;
            state      <= IDLE;
            hold_cnt   <= '0;
            led        <= '0;
            rx_count   <= '0;
            drop_count <= '0;
        end else begin
            run   <= 1'b1;
            avail <= ~empty & ~pop;
            if (push) rx_count   <= sat_inc(rx_count);
            if (drop) drop_count <= sat_inc(drop_count);
            case (state)
                IDLE: begin
                    if (avail) begin
                        led      <= head;
                        hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0)
                        state <= IDLE;
                    else
                        hold_cnt <= hold_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_led_recver.sv
// Directed bench for stream_led_recver with HOLD_CYCLES=4, FIFO_DEPTH=4.
module tb_stream_led_recver;

    typedef struct {
        bit         en;
        logic [7:0] d;
        logic [3:0] a;
    } step_t;

    typedef struct {
        logic [7:0] d;
        logic [3:0] a;
        bit         stored;
        logic [7:0] exp_led;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  expected_src = 4'h3;
    logic [7:0]  led;
    logic [15:0] rx_count;
    logic [15:0] drop_count;

    t_DATA_STREAM nap ();

    stream_led_recver #(
        .FIFO_DEPTH  (4),
        .HOLD_CYCLES (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .expected_src (expected_src),
        .nap          (nap),
        .led          (led),
        .rx_count     (rx_count),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    step_t      plan [8];
    int         np;
    logic [7:0] seen [16];
    int         seen_t [16];
    int         nseen;
    int         occ [64];
    bit         saw_block;
    vec_t       vecs [6];
    int         exp_rx;
    int         exp_drop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives plan[0..np-1] (idle steps consume one cycle), logs LED changes and occupancy.
    task automatic run_plan(input int ncyc);
        int         k;
        bit         go;
        logic [7:0] last;
        k = 0;
        last = led;
        nseen = 0;
        saw_block = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c < 64) occ[c] = int'(dut.u_fifo.count);
            if (led !== last && nseen < 16) begin
                seen[nseen] = led;
                seen_t[nseen] = c;
                nseen++;
                last = led;
            end
            go = 0;
            if (k < np && plan[k].en) begin
                nap.valid = 1'b1;
                nap.data  = plan[k].d;
                nap.addr  = plan[k].a;
                if (nap.ready) go = 1; else saw_block = 1;
            end else begin
                nap.valid = 1'b0;
                if (k < np) go = 1;
            end
            @(posedge clk);
            if (go) k++;
        end
        @(negedge clk);
        nap.valid = 1'b0;
        check("plan_all_sent", k, np);
    endtask

    task automatic set_words(input logic [7:0] w [8], input int n);
        for (int i = 0; i < 8; i++) plan[i] = '{en: 1'b1, d: w[i], a: 4'h3};
        np = n;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w [8];
        int         bad_led;

        nap.valid = 1'b0;
        nap.data  = '0;
        nap.addr  = '0;

        repeat (3) @(negedge clk);
        check("rst_ready", nap.ready, 1'b0);
        check("rst_led", led, 8'h00);
        check("rst_rx", rx_count, 16'h0);
        check("rst_drop", drop_count, 16'h0);
        resetn = 1'b1;
        @(negedge clk);
        check("ready_after_release", nap.ready, 1'b1);

        // Single words from idle; dropped words leave the LED untouched.
`ifdef RECVER_SRC_FILTER_EN
        vecs[0] = '{8'h01, 4'h3, 1'b1, 8'h01};
        vecs[1] = '{8'hAA, 4'h3, 1'b1, 8'hAA};
        vecs[2] = '{8'h55, 4'h5, 1'b0, 8'hAA};
        vecs[3] = '{8'h80, 4'h0, 1'b0, 8'hAA};
        vecs[4] = '{8'hFF, 4'h3, 1'b1, 8'hFF};
        vecs[5] = '{8'h3C, 4'hF, 1'b0, 8'hFF};
`else
        vecs[0] = '{8'h01, 4'h3, 1'b1, 8'h01};
        vecs[1] = '{8'hAA, 4'h3, 1'b1, 8'hAA};
        vecs[2] = '{8'h55, 4'h5, 1'b1, 8'h55};
        vecs[3] = '{8'h80, 4'h0, 1'b1, 8'h80};
        vecs[4] = '{8'hFF, 4'h3, 1'b1, 8'hFF};
        vecs[5] = '{8'h3C, 4'hF, 1'b1, 8'h3C};
`endif
        exp_rx = 0;
        exp_drop = 0;
        for (int i = 0; i < 6; i++) begin
            repeat (8) @(negedge clk);
            plan[0] = '{en: 1'b1, d: vecs[i].d, a: vecs[i].a};
            np = 1;
            run_plan(9);
            if (vecs[i].stored) exp_rx++; else exp_drop++;
            check($sformatf("v%0d_led_changes", i), nseen, vecs[i].stored ? 1 : 0);
            if (vecs[i].stored) check($sformatf("v%0d_latency", i), seen_t[0], 3);
            check($sformatf("v%0d_led", i), led, vecs[i].exp_led);
            check($sformatf("v%0d_rx", i), rx_count, exp_rx);
            check($sformatf("v%0d_drop", i), drop_count, exp_drop);
        end

        // Burst of six with valid held high: FIFO fills, LEDs step every 5 cycles.
        repeat (10) @(negedge clk);
        w = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h00, 8'h00};
        set_words(w, 6);
        run_plan(45);
        exp_rx += 6;
        check("burst_count", nseen, 6);
        check("burst_backpressure", saw_block, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("burst_word%0d", i), seen[i], w[i]);
            check($sformatf("burst_time%0d", i), seen_t[i], 3 + 5 * i);
        end
        check("burst_rx", rx_count, exp_rx);

        // Push+pop at occupancy 1, then pop while full with push blocked.
        repeat (10) @(negedge clk);
        w = '{8'h11, 8'h00, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00};
        set_words(w, 7);
        plan[1].en = 1'b0;
        run_plan(40);
        exp_rx += 6;
        check("occ_pushpop_at1", occ[3], 1);
        check("occ_full", occ[6], 4);
        check("occ_block_held", saw_block, 1'b1);
        check("occ_pop_at_full", occ[8], 3);
        check("occ_count", nseen, 6);
        check("occ_word0", seen[0], 8'h11);
        for (int i = 1; i < 6; i++) check($sformatf("occ_word%0d", i), seen[i], w[i + 1]);
        check("occ_rx", rx_count, exp_rx);

        // Asynchronous reset mid-HOLD with three words queued.
        repeat (10) @(negedge clk);
        w = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h00, 8'h00, 8'h00, 8'h00};
        set_words(w, 4);
        run_plan(4);
        check("pre_reset_queued", dut.u_fifo.count, 3);
        check("pre_reset_led", led, 8'h81);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_led", led, 8'h00);
        check("async_rst_ready", nap.ready, 1'b0);
        check("async_rst_rx", rx_count, 16'h0);
        repeat (2) @(negedge clk);
        check("in_rst_ready", nap.ready, 1'b0);
        resetn = 1'b1;
        @(negedge clk);
        check("rerelease_ready", nap.ready, 1'b1);
        bad_led = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (led !== 8'h00) bad_led++;
        end
        check("no_stale_words", bad_led, 0);
        check("post_rst_rx", rx_count, 16'h0);

        // Saturation of rx_count from a forced near-max value.
        @(negedge clk);
        force dut.rx_count = 16'hFFFE;
        #1 release dut.rx_count;
        w = '{8'hC1, 8'hC2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        set_words(w, 1);
        run_plan(6);
        check("sat_first", rx_count, 16'hFFFF);
        plan[0].d = 8'hC2;
        plan[1].d = 8'hC3;
        np = 2;
        run_plan(8);
        check("sat_hold", rx_count, 16'hFFFF);
        check("sat_drop", drop_count, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_led_recver.md
STREAM_LED_RECVER -- requirements
Module: stream_led_recver

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: entries in receive buffer; power of two, 2..16.
REQ-002 Parameter HOLD_CYCLES, default 20000000: clk cycles each received value is held on the LEDs (200 ms at 100 MHz); minimum 1.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port resetn  input  1  asynchronous, active-low reset.
REQ-005 Port expected_src  input  4  stream source address accepted when the filter is compiled in.
REQ-006 Port nap  t_DATA_STREAM.rx  --  NAP data-stream receive side (valid, ready, data[7:0], addr[3:0]).
REQ-007 Port led  output  8  LED drive, 1 = on.
REQ-008 Port rx_count  output  16  number of words accepted and stored.
REQ-009 Port drop_count  output  16  number of words accepted and discarded.

Function
REQ-010 A word SHALL transfer only in a cycle where nap.valid and nap.ready are both 1.
REQ-011 nap.ready SHALL be 1 exactly when the FIFO is not full, driven from a registered full flag, with no combinational dependence on nap.valid.
REQ-012 A transferred word SHALL be written to the FIFO on the same edge; data and addr are sampled only on transfer cycles.
REQ-013 Display FSM states: IDLE, HOLD.
REQ-014 IDLE with FIFO non-empty: pop head, register it to led on that edge, load hold counter with HOLD_CYCLES-1, go to HOLD; empty: stay IDLE, led unchanged.
REQ-015 HOLD: counter decrements each cycle; at 0, go to IDLE; led holds its value until the next pop.
REQ-016 Latency: a word written to an empty FIFO while in IDLE SHALL appear on led 2 cycles after its transfer edge.
REQ-017 Simultaneous push and pop SHALL both occur; occupancy unchanged.
REQ-018 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty derived from an occupancy count of width clog2(FIFO_DEPTH)+1.
REQ-019 rx_count increments by 1 per stored word; drop_count increments by 1 per discarded word; both saturate at 16'hFFFF.
REQ-020 led, rx_count, and drop_count SHALL be registered outputs.

Reset
REQ-021 resetn low SHALL asynchronously clear: FIFO occupancy and pointers to 0, FSM to IDLE, hold counter to 0, led to 8'h00, rx_count to 0, drop_count to 0; nap.ready to 0.
REQ-022 While resetn is low, nap.ready SHALL be 0; it SHALL rise on the first clk edge after reset release.
REQ-023 Reset mid-HOLD or with a non-empty FIFO SHALL discard all buffered words without emitting them.

Configuration
REQ-024 Macro RECVER_SRC_FILTER_EN defined: a transferred word with nap.addr != expected_src is accepted (ready unchanged) but not written to the FIFO; drop_count increments.
REQ-025 Macro undefined: every transferred word is stored regardless of nap.addr; drop_count SHALL be constant 0.

Structure
REQ-026 Shared package recver_pkg SHALL hold the FSM state enum (IDLE, HOLD), the LED data width (8), the address width (4), and the counter width (16).
REQ-027 The FIFO SHALL be a sub-module named stream_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, async active-low reset); the FSM and counters stay in stream_led_recver.

Verification (HOLD_CYCLES=4, FIFO_DEPTH=4 unless stated)
REQ-028 Single word 8'h01 sent from idle -> led=8'h01 2 cycles after transfer, held for 4 cycles minimum, rx_count=1.
REQ-029 Burst of 6 words 8'h01..8'h20 with valid held high -> ready drops after 4 stored, all 6 appear on led in order at 5-cycle spacing, rx_count=6.
REQ-030 Filter build, expected_src=4'h3, send addr=3 data=8'hAA then addr=5 data=8'h55 -> led shows only 8'hAA, rx_count=1, drop_count=1; non-filter build -> both shown, drop_count=0.
REQ-031 resetn asserted asynchronously mid-HOLD with 3 words queued -> led=8'h00 and ready=0 immediately, no queued word ever appears on led after release.
REQ-032 Push and pop in the same cycle at occupancy 1 and at occupancy 4 (pop only, push blocked) -> occupancy 1 and 3 respectively, no data lost or duplicated.
REQ-033 rx_count preloaded to 16'hFFFE via 3 stores forced in simulation -> reads 16'hFFFF and stays there.
